// File: rtl/byte_serial_adder_if.sv
// rtl/byte_serial_adder_if.sv - beat input and result bundle for byte_serial_adder
interface byte_serial_adder_if #(
    parameter int BEATS = 4
);
    logic                 in_valid;
    logic                 in_first;
    logic [31:0]          Shift;
    logic [8*BEATS-1:0]   sum_a;
    logic [8*BEATS-1:0]   sum_b;
    logic                 cout_a;
    logic                 cout_b;
    logic                 out_valid;
    logic                 err;

    modport master (
        output in_valid, in_first, Shift,
        input  sum_a, sum_b, cout_a, cout_b, out_valid, err
    );

    modport slave (
        input  in_valid, in_first, Shift,
        output sum_a, sum_b, cout_a, cout_b, out_valid, err
    );
endinterface

// File: rtl/byte_serial_adder.sv
// rtl/byte_serial_adder.sv - byte-serial dual adder, lane0+lane1 and lane2+lane3 (or lane2-lane3 with BSA_SUB_EN)
module byte_serial_adder #(
    parameter int BEATS = 4
) (
    input logic               clk,
    input logic               reset,
    byte_serial_adder_if.slave bus
);
    localparam int W  = 8 * BEATS;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

`ifdef BSA_SUB_EN
    localparam logic B_CIN = 1'b1;
    logic [7:0] b_opnd;
    assign b_opnd = ~bus.Shift[31:24];
`else
    localparam logic B_CIN = 1'b0;
    logic [7:0] b_opnd;
    assign b_opnd = bus.Shift[31:24];
`endif

    typedef enum logic {IDLE, ACC} state_t;
    state_t state_q, state_d;

    logic [CW-1:0] cnt;
    logic          ca, cb;
    logic [W-9:0]  acc_a, acc_b;

    logic load_first, load_next, set_err, done;

    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        load_next  = 1'b0;
        set_err    = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_first) begin
                        load_first = 1'b1;
                        state_d    = ACC;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            ACC: begin
                if (bus.in_valid) begin
                    if (bus.in_first) begin
                        load_first = 1'b1;
                        set_err    = 1'b1;
                    end else begin
                        load_next = 1'b1;
                        if (cnt == LAST) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh operand set starts with the pair's base carry-in, otherwise the ripple carry.
    logic       cin_a, cin_b;
    logic [8:0] byte_a, byte_b;
    logic [W-1:0] full_a, full_b;

    assign cin_a  = load_first ? 1'b0  : ca;
    assign cin_b  = load_first ? B_CIN : cb;
    assign byte_a = {1'b0, bus.Shift[7:0]} + {1'b0, bus.Shift[15:8]} + {8'd0, cin_a};
    assign byte_b = {1'b0, bus.Shift[23:16]} + {1'b0, b_opnd} + {8'd0, cin_b};

    // New byte enters at the top; after BEATS beats byte 0 has reached the bottom.
    assign full_a = {byte_a[7:0], acc_a};
    assign full_b = {byte_b[7:0], acc_b};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt           <= '0;
            ca            <= 1'b0;
            cb            <= 1'b0;
            acc_a         <= '0;
            acc_b         <= '0;
            bus.sum_a     <= '0;
            bus.sum_b     <= '0;
            bus.cout_a    <= 1'b0;
            bus.cout_b    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus.out_valid <= done;
            bus.err       <= bus.err | set_err;
            if (load_first || load_next) begin
                ca    <= byte_a[8];
                cb    <= byte_b[8];
                acc_a <= full_a[W-1:8];
                acc_b <= full_b[W-1:8];
            end
            if (load_first) begin
                cnt <= CW'(1);
            end else if (done) begin
                cnt <= '0;
            end else if (load_next) begin
                cnt <= cnt + CW'(1);
            end
            if (done) begin
                bus.sum_a  <= full_a;
                bus.sum_b  <= full_b;
                bus.cout_a <= byte_a[8];
                bus.cout_b <= byte_b[8];
            end
        end
    end
endmodule

// File: tb/tb_byte_serial_adder.sv
// tb/tb_byte_serial_adder.sv - self-checking bench for byte_serial_adder
module tb_byte_serial_adder;
    localparam int BEATS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    byte_serial_adder_if #(.BEATS(BEATS)) bus ();
    byte_serial_adder #(.BEATS(BEATS)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;
    logic [32:0] last_a, last_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic f, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_first = f;
        bus.Shift    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        cycle(1'b0, 1'($urandom), $urandom);
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] l0, l1, l2, l3, input int k);
        return {l3[8*k +: 8], l2[8*k +: 8], l1[8*k +: 8], l0[8*k +: 8]};
    endfunction

    function automatic logic [32:0] ref_a(input logic [31:0] l0, l1);
        return {1'b0, l0} + {1'b0, l1};
    endfunction

    function automatic logic [32:0] ref_b(input logic [31:0] l2, l3);
`ifdef BSA_SUB_EN
        return {l2 >= l3, l2 - l3};
`else
        return {1'b0, l2} + {1'b0, l3};
`endif
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_sum_a"}, 64'(bus.sum_a), 0);
        chk({tag, "_sum_b"}, 64'(bus.sum_b), 0);
        chk({tag, "_cout_a"}, 64'(bus.cout_a), 0);
        chk({tag, "_cout_b"}, 64'(bus.cout_b), 0);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 0);
        chk({tag, "_err"}, 64'(bus.err), 0);
    endtask

    task automatic send_set(input string tag, input logic [31:0] l0, l1, l2, l3,
                            input int bub_after, input int nbub);
        last_a = ref_a(l0, l1);
        last_b = ref_b(l2, l3);
        for (int k = 0; k < BEATS; k++) begin
            cycle(1'b1, k == 0, beat_data(l0, l1, l2, l3, k));
            if (k < BEATS - 1) begin
                chk({tag, "_ov_mid"}, 64'(bus.out_valid), 0);
                if (k == bub_after) begin
                    for (int j = 0; j < nbub; j++) begin
                        bubble();
                        chk({tag, "_ov_bubble"}, 64'(bus.out_valid), 0);
                    end
                end
            end
        end
        chk({tag, "_ov"}, 64'(bus.out_valid), 1);
        chk({tag, "_sum_a"}, 64'(bus.sum_a), 64'(last_a[31:0]));
        chk({tag, "_cout_a"}, 64'(bus.cout_a), 64'(last_a[32]));
        chk({tag, "_sum_b"}, 64'(bus.sum_b), 64'(last_b[31:0]));
        chk({tag, "_cout_b"}, 64'(bus.cout_b), 64'(last_b[32]));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle(1'b0, 1'b0, 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] x0, x1, x2, x3;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.Shift    = '0;
        repeat (3) cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
        chk_zero("reset");
        reset = 1'b1;

        send_set("t1", 32'h12345678, 32'h11111111, 32'h0000FFFF, 32'h00000001, -1, 0);
        chk("t1_sum_a_const", 64'(bus.sum_a), 64'h23456789);
        chk("t1_cout_a_const", 64'(bus.cout_a), 0);
`ifndef BSA_SUB_EN
        chk("t1_sum_b_const", 64'(bus.sum_b), 64'h00010000);
        chk("t1_cout_b_const", 64'(bus.cout_b), 0);
`endif
        cycle(1'b0, 1'b0, 32'd0);
        chk("t1_ov_drop", 64'(bus.out_valid), 0);

        send_set("t2", 32'hFFFFFFFF, 32'h00000001, $urandom, $urandom, 1, 2);
        chk("t2_sum_a_const", 64'(bus.sum_a), 0);
        chk("t2_cout_a_const", 64'(bus.cout_a), 1);

        send_set("t3a", $urandom, $urandom, $urandom, $urandom, -1, 0);
        send_set("t3b", $urandom, $urandom, $urandom, $urandom, -1, 0);
        chk("t3_err", 64'(bus.err), 0);
        repeat (3) bubble();
        chk("hold_ov", 64'(bus.out_valid), 0);
        chk("hold_sum_a", 64'(bus.sum_a), 64'(last_a[31:0]));
        chk("hold_sum_b", 64'(bus.sum_b), 64'(last_b[31:0]));

        x0 = $urandom; x1 = $urandom; x2 = $urandom; x3 = $urandom;
        cycle(1'b1, 1'b1, beat_data(x0, x1, x2, x3, 0));
        cycle(1'b1, 1'b0, beat_data(x0, x1, x2, x3, 1));
        chk("t4_err_before", 64'(bus.err), 0);
        send_set("t4", $urandom, $urandom, $urandom, $urandom, -1, 0);
        chk("t4_err", 64'(bus.err), 1);

        cycle(1'b1, 1'b1, beat_data(x0, x1, x2, x3, 0));
        cycle(1'b1, 1'b0, beat_data(x0, x1, x2, x3, 1));
        reset = 1'b0;
        cycle(1'b1, 1'b0, beat_data(x0, x1, x2, x3, 2));
        reset = 1'b1;
        chk_zero("t5_reset");
        cycle(1'b1, 1'b0, beat_data(x0, x1, x2, x3, 3));
        chk("t5_idle_ov", 64'(bus.out_valid), 0);
        chk("t5_idle_err", 64'(bus.err), 1);
        send_set("t5", $urandom, $urandom, $urandom, $urandom, 2, 1);

        do_reset();
        send_set("t6a", $urandom, $urandom, 32'd5, 32'd7, -1, 0);
`ifdef BSA_SUB_EN
        chk("t6a_sum_b_const", 64'(bus.sum_b), 64'hFFFFFFFE);
        chk("t6a_cout_b_const", 64'(bus.cout_b), 0);
`else
        chk("t6a_sum_b_const", 64'(bus.sum_b), 64'd12);
        chk("t6a_cout_b_const", 64'(bus.cout_b), 0);
`endif
        send_set("t6b", $urandom, $urandom, 32'd7, 32'd5, -1, 0);
`ifdef BSA_SUB_EN
        chk("t6b_sum_b_const", 64'(bus.sum_b), 64'd2);
        chk("t6b_cout_b_const", 64'(bus.cout_b), 1);
`else
        chk("t6b_sum_b_const", 64'(bus.sum_b), 64'd12);
        chk("t6b_cout_b_const", 64'(bus.cout_b), 0);
`endif
        send_set("t6c", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0);

        for (int i = 0; i < 30; i++) begin
            send_set("rnd", $urandom, $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) bubble();
        end
        chk("rnd_err", 64'(bus.err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
